// File: rtl/mem_access_unit.sv
// Load/store unit: accepts one RV-style load or store, drives a single word-wide
// memory access, and returns the lane-extracted, extended load result.
module mem_access_unit #(
    parameter int XLEN   = 32,
    parameter int NBYTES = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [XLEN-1:0]   mem_address,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [NBYTES-1:0] mem_byte_enable,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_resp,
    output logic [1:0]        dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // resp_valid is a single-cycle strobe with no back-pressure.

    localparam int OFF_W = $clog2(NBYTES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state, state_next;
    logic              wr_q;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   rdata_q;
    logic              err_q;

    logic              f3_legal;
    logic              misaligned;
    logic              req_err;
    logic [OFF_W-1:0]  offset;
    logic [OFF_W+2:0]  shamt;
    logic [NBYTES-1:0] be_base;
    logic [XLEN-1:0]   ld_shift;
    logic [XLEN-1:0]   ld_ext;

    // Legality of the offered request, evaluated on the live inputs at acceptance.
    always_comb begin
        f3_legal   = 1'b0;
        misaligned = 1'b0;
        if (req_write) begin
            case (funct3)
                3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
                3'b011:                 f3_legal = (XLEN == 64);
                default:                f3_legal = 1'b0;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
                3'b011, 3'b110:                         f3_legal = (XLEN == 64);
                default:                                f3_legal = 1'b0;
            endcase
        end
        case (funct3[1:0])
            2'b01:   misaligned = (req_addr[0] != 1'b0);
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            2'b11:   misaligned = (req_addr[2:0] != 3'b000);
            default: misaligned = 1'b0;
        endcase
        req_err = !f3_legal || misaligned;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            wr_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid) begin
                wr_q    <= req_write;
                f3_q    <= funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= req_err;
            end
            if (state == ACCESS && mem_resp && !wr_q) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = req_err ? DONE : ACCESS;
            ACCESS:  if (mem_resp) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Lane mask for the access size, before shifting to the byte offset.
    always_comb begin
        offset = addr_q[OFF_W-1:0];
        shamt  = {offset, 3'b000};
        case (f3_q[1:0])
            2'b00:   be_base = NBYTES'(1);
            2'b01:   be_base = NBYTES'(3);
            2'b10:   be_base = NBYTES'(15);
            default: be_base = NBYTES'(255);
        endcase
    end

    always_comb begin
        ld_shift = rdata_q >> shamt;
        case (f3_q)
            3'b000:  ld_ext = XLEN'($signed(ld_shift[7:0]));
            3'b001:  ld_ext = XLEN'($signed(ld_shift[15:0]));
            3'b010:  ld_ext = XLEN'($signed(ld_shift[31:0]));
            3'b100:  ld_ext = XLEN'(ld_shift[7:0]);
            3'b101:  ld_ext = XLEN'(ld_shift[15:0]);
            3'b110:  ld_ext = XLEN'(ld_shift[31:0]);
            default: ld_ext = ld_shift;
        endcase
    end

    always_comb begin
        req_ready       = (state == IDLE);
        mem_read        = (state == ACCESS) && !wr_q;
        mem_write       = (state == ACCESS) && wr_q;
        mem_address     = (state == ACCESS) ? {addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
        mem_wdata       = mem_write ? (wdata_q << shamt) : '0;
        mem_byte_enable = mem_write ? (be_base << offset) : '0;
        resp_valid      = (state == DONE);
        resp_err        = (state == DONE) && err_q;
        resp_rdata      = ((state == DONE) && !err_q && !wr_q) ? ld_ext : '0;
        dbg_state       = state;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table applied to an XLEN=32 and an
// XLEN=64 instance, plus reset-during-access sequences.
module tb_mem_access_unit;

    typedef struct {
        bit          sel64;
        bit          wr;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          waits;
        bit          err;
        logic [63:0] exp_rdata;
        logic [63:0] exp_addr;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_be;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        sel64;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [63:0] mem_rdata;
    logic        mem_resp;

    logic        r32_ready, r32_rv, r32_err, r32_rd, r32_wr;
    logic [31:0] r32_rdata, r32_addr, r32_wdata;
    logic [3:0]  r32_be;
    logic [1:0]  r32_st;
    logic        r64_ready, r64_rv, r64_err, r64_rd, r64_wr;
    logic [63:0] r64_rdata, r64_addr, r64_wdata;
    logic [7:0]  r64_be;
    logic [1:0]  r64_st;

    logic        o_ready, o_rv, o_err, o_rd, o_wr;
    logic [63:0] o_rdata, o_addr, o_wdata;
    logic [7:0]  o_be;
    logic [1:0]  o_st;

    int          n_tests;
    int          n_fail;
    logic [63:0] exp_q[$];
    vec_t        vecs[$];

    mem_access_unit #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && !sel64), .req_ready(r32_ready),
        .req_write(req_write), .funct3(funct3),
        .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
        .resp_valid(r32_rv), .resp_rdata(r32_rdata), .resp_err(r32_err),
        .mem_read(r32_rd), .mem_write(r32_wr),
        .mem_address(r32_addr), .mem_wdata(r32_wdata), .mem_byte_enable(r32_be),
        .mem_rdata(mem_rdata[31:0]), .mem_resp(mem_resp && !sel64),
        .dbg_state(r32_st)
    );

    mem_access_unit #(.XLEN(64)) u_dut64 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && sel64), .req_ready(r64_ready),
        .req_write(req_write), .funct3(funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(r64_rv), .resp_rdata(r64_rdata), .resp_err(r64_err),
        .mem_read(r64_rd), .mem_write(r64_wr),
        .mem_address(r64_addr), .mem_wdata(r64_wdata), .mem_byte_enable(r64_be),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp && sel64),
        .dbg_state(r64_st)
    );

    assign o_ready = sel64 ? r64_ready : r32_ready;
    assign o_rv    = sel64 ? r64_rv    : r32_rv;
    assign o_err   = sel64 ? r64_err   : r32_err;
    assign o_rd    = sel64 ? r64_rd    : r32_rd;
    assign o_wr    = sel64 ? r64_wr    : r32_wr;
    assign o_rdata = sel64 ? r64_rdata : {32'b0, r32_rdata};
    assign o_addr  = sel64 ? r64_addr  : {32'b0, r32_addr};
    assign o_wdata = sel64 ? r64_wdata : {32'b0, r32_wdata};
    assign o_be    = sel64 ? r64_be    : {4'b0, r32_be};
    assign o_st    = sel64 ? r64_st    : r32_st;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " ready"}, o_ready, 1);
        chk({tag, " resp_valid"}, o_rv, 0);
        chk({tag, " resp_err"}, o_err, 0);
        chk({tag, " mem_read"}, o_rd, 0);
        chk({tag, " mem_write"}, o_wr, 0);
        chk({tag, " resp_rdata"}, o_rdata, 0);
        chk({tag, " mem_address"}, o_addr, 0);
        chk({tag, " mem_wdata"}, o_wdata, 0);
        chk({tag, " byte_enable"}, o_be, 0);
        chk({tag, " state"}, o_st, 0);
    endtask

    function automatic vec_t mk(input bit s64, input bit wr, input logic [2:0] f3,
                                input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [63:0] rdata, input int waits, input bit err,
                                input logic [63:0] exp_rdata, input logic [63:0] exp_addr,
                                input logic [63:0] exp_wdata, input logic [7:0] exp_be);
        vec_t v;
        v.sel64 = s64; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.waits = waits; v.err = err; v.exp_rdata = exp_rdata;
        v.exp_addr = exp_addr; v.exp_wdata = exp_wdata; v.exp_be = exp_be;
        return v;
    endfunction

    task automatic drive_request(input vec_t v);
        req_valid = 1'b1;
        req_write = v.wr;
        funct3    = v.f3;
        req_addr  = v.addr;
        req_wdata = v.wdata;
    endtask

    task automatic scramble_request();
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1));
        funct3    = 3'($urandom_range(0, 7));
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag   = $sformatf("v%0d", idx);
        sel64 = v.sel64;
        @(negedge clk);
        chk({tag, " ready_before"}, o_ready, 1);
        drive_request(v);
        exp_q.push_back(v.err ? 64'd0 : v.exp_rdata);
        @(negedge clk);
        scramble_request();
        if (!v.err) begin
            for (int w = 0; w <= v.waits; w++) begin
                chk({tag, " mem_read"}, o_rd, !v.wr);
                chk({tag, " mem_write"}, o_wr, v.wr);
                chk({tag, " mem_address"}, o_addr, v.exp_addr);
                chk({tag, " byte_enable"}, o_be, v.exp_be);
                if (v.wr) chk({tag, " mem_wdata"}, o_wdata, v.exp_wdata);
                chk({tag, " early_resp_valid"}, o_rv, 0);
                chk({tag, " ready_busy"}, o_ready, 0);
                mem_resp  = (w == v.waits);
                mem_rdata = (mem_resp && !v.wr) ? v.rdata : {$urandom, $urandom};
                @(negedge clk);
            end
            mem_resp = 1'b0;
        end
        chk({tag, " resp_valid"}, o_rv, 1);
        chk({tag, " resp_err"}, o_err, v.err);
        chk({tag, " done_mem_read"}, o_rd, 0);
        chk({tag, " done_mem_write"}, o_wr, 0);
        chk({tag, " resp_rdata"}, o_rdata, exp_q.pop_front());
        mem_resp  = 1'b1;
        mem_rdata = {$urandom, $urandom};
        @(negedge clk);
        mem_resp = 1'b0;
        chk({tag, " resp_valid_after"}, o_rv, 0);
        chk({tag, " ready_after"}, o_ready, 1);
    endtask

    task automatic reset_during_access(input bit s64);
        vec_t v;
        v = mk(s64, 0, 3'b010, 64'h40, 0, 0, 0, 0, 0, 64'h40, 0, 0);
        sel64 = s64;
        @(negedge clk);
        drive_request(v);
        @(negedge clk);
        scramble_request();
        chk("rst_acc mem_read", o_rd, 1);
        chk("rst_acc mem_address", o_addr, 64'h40);
        #2 rst = 1'b1;
        #1 chk_reset_vals("rst_async");
        @(negedge clk);
        rst       = 1'b0;
        mem_resp  = 1'b1;
        mem_rdata = 64'h1111_2222_3333_4444;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_late_resp_valid", o_rv, 0);
            chk("rst_late_ready", o_ready, 1);
            chk("rst_late_mem_read", o_rd, 0);
        end
        mem_resp = 1'b0;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        sel64     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        funct3    = 3'b000;
        req_addr  = '0;
        req_wdata = '0;
        mem_rdata = '0;
        mem_resp  = 1'b0;

        // XLEN=32 vectors
        vecs.push_back(mk(0, 0, 3'b000, 64'h103, 0, 64'h80FF_0000, 3, 0, 64'hFFFF_FF80, 64'h100, 0, 8'h0));
        vecs.push_back(mk(0, 0, 3'b101, 64'h102, 0, 64'hBEEF_1234, 0, 0, 64'h0000_BEEF, 64'h100, 0, 8'h0));
        vecs.push_back(mk(0, 1, 3'b001, 64'h22, 64'h1234_ABCD, 0, 2, 0, 0, 64'h20, 64'hABCD_0000, 8'hC));
        vecs.push_back(mk(0, 0, 3'b010, 64'h101, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3'b011, 64'h100, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3'b100, 64'h201, 0, 64'h1234_F056, 1, 0, 64'h0000_00F0, 64'h200, 0, 8'h0));
        vecs.push_back(mk(0, 0, 3'b001, 64'h200, 0, 64'h1234_8001, 0, 0, 64'hFFFF_8001, 64'h200, 0, 8'h0));
        vecs.push_back(mk(0, 0, 3'b010, 64'h204, 0, 64'hDEAD_BEEF, 0, 0, 64'hDEAD_BEEF, 64'h204, 0, 8'h0));
        vecs.push_back(mk(0, 0, 3'b000, 64'h102, 0, 64'h0055_0000, 1, 0, 64'h0000_0055, 64'h100, 0, 8'h0));
        vecs.push_back(mk(0, 1, 3'b000, 64'h3, 64'h0000_00AB, 0, 0, 0, 0, 64'h0, 64'hAB00_0000, 8'h8));
        vecs.push_back(mk(0, 1, 3'b010, 64'h8, 64'hCAFE_F00D, 0, 1, 0, 0, 64'h8, 64'hCAFE_F00D, 8'hF));
        vecs.push_back(mk(0, 1, 3'b100, 64'h0, 64'h1, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3'b111, 64'h0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3'b001, 64'h1, 64'h1, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3'b001, 64'h103, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3'b110, 64'h0, 0, 0, 0, 1, 0, 0, 0, 0));
        // XLEN=64 vectors
        vecs.push_back(mk(1, 0, 3'b110, 64'h4, 0, 64'h8000_0001_0000_0000, 1, 0, 64'h0000_0000_8000_0001, 64'h0, 0, 8'h0));
        vecs.push_back(mk(1, 0, 3'b010, 64'hC, 0, 64'h8000_0001_0000_0000, 0, 0, 64'hFFFF_FFFF_8000_0001, 64'h8, 0, 8'h0));
        vecs.push_back(mk(1, 0, 3'b011, 64'h10, 0, 64'h0123_4567_89AB_CDEF, 2, 0, 64'h0123_4567_89AB_CDEF, 64'h10, 0, 8'h0));
        vecs.push_back(mk(1, 1, 3'b011, 64'h18, 64'hFEDC_BA98_7654_3210, 0, 0, 0, 0, 64'h18, 64'hFEDC_BA98_7654_3210, 8'hFF));
        vecs.push_back(mk(1, 1, 3'b010, 64'h24, 64'h0000_0000_DEAD_BEEF, 0, 1, 0, 0, 64'h20, 64'hDEAD_BEEF_0000_0000, 8'hF0));
        vecs.push_back(mk(1, 0, 3'b011, 64'h4, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 3'b110, 64'h0, 64'h1, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 3'b111, 64'h0, 0, 0, 0, 1, 0, 0, 0, 0));

        #1 chk_reset_vals("reset32");
        sel64 = 1'b1;
        #1 chk_reset_vals("reset64");
        sel64 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        reset_during_access(1'b0);
        run_vec(vecs[1], 100);
        reset_during_access(1'b1);
        run_vec(vecs[16], 101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
